// File: rtl/timx_pkg.sv
// Shared definitions for the TIMx APB initiator: FSM encoding, timer register
// map and a small address helper.
package timx_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    // TIMx register byte offsets
    localparam logic [15:0] ADDR_CR1   = 16'h0000;
    localparam logic [15:0] ADDR_SMCR  = 16'h0008;
    localparam logic [15:0] ADDR_DIER  = 16'h000C;
    localparam logic [15:0] ADDR_SR    = 16'h0010;
    localparam logic [15:0] ADDR_CCMR1 = 16'h0018;
    localparam logic [15:0] ADDR_CCER  = 16'h0020;
    localparam logic [15:0] ADDR_ARR   = 16'h002C;

    // Registers are 32-bit; only word-aligned byte addresses reach the bus.
    function automatic logic addr_aligned(input logic [15:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/timx_apb_master.sv
// APB initiator that turns single command/response handshakes into APB
// SETUP/ACCESS transfers towards a TIMx peripheral, with a bounded wait for
// pready and rejection of misaligned addresses. Every output is a flop.
module timx_apb_master
    import timx_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        apb_clk,
    input  logic        apb_rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [15:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_timeout,
    output logic        timx_psel,
    output logic        timx_penable,
    output logic        timx_pwrite,
    output logic [15:0] timx_paddr,
    output logic [31:0] timx_pwdata,
    input  logic [31:0] timx_prdata,
    input  logic        timx_pready,
    input  logic        timx_pslverr
);

    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT_CYCLES);
    localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);

    logic [1:0]        state_q,       state_d;
    logic [WAIT_W-1:0] wait_q,        wait_d;
    logic              cmd_ready_q,   cmd_ready_d;
    logic              rsp_valid_q,   rsp_valid_d;
    logic [31:0]       rsp_rdata_q,   rsp_rdata_d;
    logic              rsp_err_q,     rsp_err_d;
    logic              rsp_timeout_q, rsp_timeout_d;
    logic              psel_q,        psel_d;
    logic              penable_q,     penable_d;
    logic              pwrite_q,      pwrite_d;
    logic [15:0]       paddr_q,       paddr_d;
    logic [31:0]       pwdata_q,      pwdata_d;
    logic [WAIT_W-1:0] wait_inc_s;

    // Next-state and next-output computation for the transfer FSM
    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        cmd_ready_d   = cmd_ready_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        wait_inc_s    = wait_q + WAIT_ONE;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    if (addr_aligned(cmd_addr)) begin
                        // Latch the command and start the APB setup phase
                        pwrite_d  = cmd_write;
                        paddr_d   = cmd_addr;
                        pwdata_d  = cmd_wdata;
                        psel_d    = 1'b1;
                        penable_d = 1'b0;
                        wait_d    = '0;
                        state_d   = ST_SETUP;
                    end else begin
                        // Misaligned: answer with an error without touching the bus
                        rsp_valid_d   = 1'b1;
                        rsp_err_d     = 1'b1;
                        rsp_timeout_d = 1'b0;
                        rsp_rdata_d   = 32'h0000_0000;
                        state_d       = ST_RESP;
                    end
                end else begin
                    // Readiness appears one cycle after reset release
                    cmd_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end

            ST_SETUP: begin
                penable_d = 1'b1;
                state_d   = ST_ACCESS;
            end

            ST_ACCESS: begin
                if (timx_pready) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_rdata_d   = pwrite_q ? 32'h0000_0000 : timx_prdata;
                    rsp_err_d     = timx_pslverr;
                    rsp_timeout_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = ST_RESP;
                end else if (wait_inc_s == WAIT_LIMIT) begin
                    // Slave stalled for the full budget: drop the bus and report
                    wait_d        = wait_inc_s;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_rdata_d   = 32'h0000_0000;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_valid_d   = 1'b1;
                    state_d       = ST_RESP;
                end else begin
                    wait_d  = wait_inc_s;
                    state_d = ST_ACCESS;
                end
            end

            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end

            default: begin
                // Unreachable encoding: recover to a quiet idle bus
                state_d     = ST_IDLE;
                psel_d      = 1'b0;
                penable_d   = 1'b0;
                rsp_valid_d = 1'b0;
                cmd_ready_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge apb_clk) begin
        if (!apb_rst_n) begin
            state_q       <= ST_IDLE;
            wait_q        <= '0;
            cmd_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= 32'h0000_0000;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= 16'h0000;
            pwdata_q      <= 32'h0000_0000;
        end else begin
            state_q       <= state_d;
            wait_q        <= wait_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
        end
    end

    assign cmd_ready    = cmd_ready_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign rsp_err      = rsp_err_q;
    assign rsp_timeout  = rsp_timeout_q;
    assign timx_psel    = psel_q;
    assign timx_penable = penable_q;
    assign timx_pwrite  = pwrite_q;
    assign timx_paddr   = paddr_q;
    assign timx_pwdata  = pwdata_q;

endmodule

// File: tb/tb_timx_apb_master.sv
// Self-checking bench for timx_apb_master: directed scenarios plus random
// transfers, each compared with a transaction-level expectation.
module tb_timx_apb_master;
    import timx_pkg::*;

    localparam int TMO = 4;

    logic        clk;
    logic        apb_rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [15:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [15:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    timx_apb_master #(.TIMEOUT_CYCLES(TMO)) dut (
        .apb_clk      (clk),
        .apb_rst_n    (apb_rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_write    (cmd_write),
        .cmd_addr     (cmd_addr),
        .cmd_wdata    (cmd_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .rsp_timeout  (rsp_timeout),
        .timx_psel    (psel),
        .timx_penable (penable),
        .timx_pwrite  (pwrite),
        .timx_paddr   (paddr),
        .timx_pwdata  (pwdata),
        .timx_prdata  (prdata),
        .timx_pready  (pready),
        .timx_pslverr (pslverr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // One full command/response transaction. The slave raises pready after
    // 'waits' stalled ACCESS cycles; the response is held off for rsp_delay.
    task automatic run_txn(input string name, input logic wr, input logic [15:0] addr,
                           input logic [31:0] wdata, input int waits, input logic slverr,
                           input logic [31:0] rdata, input int rsp_delay, output int acc_cyc);
        logic        aligned, tmo, exp_err, bus_ok, stable;
        logic [31:0] exp_rdata;
        int          exp_pen, exp_psel, exp_lat, n_psel, n_pen, lat;
        bit          got;
        logic [34:0] snap;

        aligned   = (addr[1:0] == 2'b00);
        tmo       = aligned && (waits >= TMO);
        exp_pen   = !aligned ? 0 : (tmo ? TMO : waits + 1);
        exp_psel  = aligned ? exp_pen + 1 : 0;
        exp_lat   = aligned ? exp_pen + 2 : 1;
        exp_err   = !aligned || tmo || slverr;
        exp_rdata = (aligned && !tmo && !wr) ? rdata : 32'h0;

        for (int i = 0; i < 8 && cmd_ready !== 1'b1; i++) @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s cmd_ready_idle: got %b expected 1", name, cmd_ready);
        end

        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        acc_cyc   = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_addr  = 16'($urandom);
        cmd_wdata = $urandom;
        cmd_write = 1'($urandom);

        lat = 1; n_psel = 0; n_pen = 0; got = 0; bus_ok = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            if (rsp_valid === 1'b1) begin
                got = 1;
            end else begin
                if (psel === 1'b1) begin
                    n_psel++;
                    if (paddr !== addr || pwrite !== wr || (wr && pwdata !== wdata)) bus_ok = 1'b0;
                end
                if (penable === 1'b1) begin
                    n_pen++;
                    pready  = ((n_pen - 1) == waits);
                    prdata  = pready ? rdata : $urandom;
                    pslverr = pready ? slverr : 1'b0;
                end else begin
                    pready  = 1'b0;
                end
                @(negedge clk);
                lat++;
            end
        end
        pready  = 1'b0;
        pslverr = 1'b0;

        checks++;
        if (!got || lat != exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d (valid=%0d) expected %0d", name, lat, got, exp_lat);
        end
        checks++;
        if (n_psel != exp_psel || n_pen != exp_pen) begin
            errors++;
            $display("FAIL %s phases: got psel=%0d penable=%0d expected psel=%0d penable=%0d",
                     name, n_psel, n_pen, exp_psel, exp_pen);
        end
        checks++;
        if (!bus_ok) begin
            errors++;
            $display("FAIL %s bus_fields: got unstable paddr/pwrite/pwdata expected %h/%b/%h",
                     name, addr, wr, wdata);
        end
        checks++;
        if (rsp_rdata !== exp_rdata || rsp_err !== exp_err || rsp_timeout !== tmo) begin
            errors++;
            $display("FAIL %s response: got rdata=%h err=%b tmo=%b expected rdata=%h err=%b tmo=%b",
                     name, rsp_rdata, rsp_err, rsp_timeout, exp_rdata, exp_err, tmo);
        end
        checks++;
        if (psel !== 1'b0 || penable !== 1'b0 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s resp_bus_idle: got psel=%b penable=%b cmd_ready=%b expected 0/0/0",
                     name, psel, penable, cmd_ready);
        end

        snap   = {rsp_valid, rsp_err, rsp_timeout, rsp_rdata};
        stable = 1'b1;
        for (int i = 0; i < rsp_delay; i++) begin
            @(negedge clk);
            if ({rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== snap || cmd_ready !== 1'b0
                || psel !== 1'b0) stable = 1'b0;
        end
        if (rsp_delay > 0) begin
            checks++;
            if (!stable) begin
                errors++;
                $display("FAIL %s resp_hold: got changing response expected stable %h", name, snap);
            end
        end

        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s return_idle: got rsp_valid=%b cmd_ready=%b expected 0/1",
                     name, rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_reset();
        apb_rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 16'h0; cmd_wdata = 32'h0;
        rsp_ready = 1'b0; prdata = 32'h0; pready = 1'b0; pslverr = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, psel, penable, pwrite,
             paddr, pwdata} !== 87'h0) begin
            errors++;
            $display("FAIL reset_outputs: got ready=%b valid=%b psel=%b paddr=%h pwdata=%h rdata=%h expected all 0",
                     cmd_ready, rsp_valid, psel, paddr, pwdata, rsp_rdata);
        end
        apb_rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b expected 1", cmd_ready);
        end
    endtask

    task automatic test_write_arr();
        int t;
        run_txn("write_arr", 1'b1, ADDR_ARR, 32'h0000_0036, 0, 1'b0, 32'h0, 0, t);
    endtask

    task automatic test_read_sr();
        int t;
        run_txn("read_sr", 1'b0, ADDR_SR, 32'h0, 3, 1'b0, 32'h0000_0040, 1, t);
    endtask

    task automatic test_slverr();
        int t;
        run_txn("write_slverr", 1'b1, ADDR_CCER, 32'hA5A5_0001, 1, 1'b1, 32'h0, 0, t);
    endtask

    task automatic test_timeout();
        int t;
        run_txn("timeout", 1'b0, ADDR_CR1, 32'h0, 20, 1'b0, 32'hDEAD_BEEF, 0, t);
    endtask

    task automatic test_misaligned();
        int t;
        run_txn("misaligned", 1'b1, 16'h0002, 32'h1234_5678, 0, 1'b0, 32'h0, 5, t);
    endtask

    task automatic test_reset_access();
        int t;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = ADDR_DIER; cmd_wdata = 32'h0;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (penable !== 1'b1 || psel !== 1'b1) begin
            errors++;
            $display("FAIL rst_access_reach: got psel=%b penable=%b expected 1/1", psel, penable);
        end
        apb_rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (psel !== 1'b0 || penable !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_access_abort: got psel=%b penable=%b valid=%b ready=%b expected 0/0/0/0",
                     psel, penable, rsp_valid, cmd_ready);
        end
        apb_rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_access_idle: got ready=%b valid=%b expected 1/0", cmd_ready, rsp_valid);
        end
        run_txn("post_reset_write", 1'b1, ADDR_SMCR, 32'h0000_00C3, 0, 1'b0, 32'h0, 0, t);
    endtask

    task automatic test_back_to_back();
        int t0, t1, t2;
        run_txn("b2b_0", 1'b1, ADDR_CCMR1, 32'h0000_1111, 0, 1'b0, 32'h0, 0, t0);
        run_txn("b2b_1", 1'b0, ADDR_SR, 32'h0, 0, 1'b0, 32'h0000_2222, 0, t1);
        run_txn("b2b_2", 1'b1, ADDR_CR1, 32'h0000_0001, 0, 1'b0, 32'h0, 0, t2);
        checks++;
        if ((t1 - t0) != 4 || (t2 - t1) != 4) begin
            errors++;
            $display("FAIL b2b_throughput: got %0d,%0d cycles expected 4,4", t1 - t0, t2 - t1);
        end
    endtask

    task automatic test_random();
        int          t;
        logic [15:0] a;
        for (int n = 0; n < 20; n++) begin
            a = 16'($urandom_range(0, 16'h3F) << 2);
            if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
            run_txn("random", 1'($urandom), a, $urandom, $urandom_range(0, 5),
                    1'($urandom_range(0, 3) == 0), $urandom, $urandom_range(0, 3), t);
        end
    endtask

    initial begin
        test_reset();
        test_write_arr();
        test_read_sr();
        test_slverr();
        test_timeout();
        test_misaligned();
        test_reset_access();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
